// File: rtl/cok_cevrim_denetleyici_pkg.sv
// Shared types for the multi-cycle M-extension controller: operation codes and FSM states.
package cok_cevrim_denetleyici_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } mop_e;

    typedef enum logic [1:0] {
        StBosta = 2'd0,
        StBekle = 2'd1,
        StSonuc = 2'd2
    } durum_e;

endpackage

// File: rtl/cok_cevrim_denetleyici_if.sv
// Bundles the execute-stage request/result and the iterative unit start/done signals.
interface cok_cevrim_denetleyici_if #(
    parameter int unsigned VERI_BIT   = 32,
    parameter int unsigned ETIKET_BIT = 4
);
    logic                  istek_gecerli_i;
    logic [2:0]            istek_kod_i;
    logic [VERI_BIT-1:0]   istek_islec1_i;
    logic [VERI_BIT-1:0]   istek_islec2_i;
    logic [ETIKET_BIT-1:0] istek_etiket_i;
    logic                  bosalt_i;
    logic                  cek_duraklat_i;
    logic                  duraklat_o;
    logic                  birim_baslat_o;
    logic [2:0]            birim_kod_o;
    logic [VERI_BIT-1:0]   birim_islec1_o;
    logic [VERI_BIT-1:0]   birim_islec2_o;
    logic                  birim_iptal_o;
    logic                  birim_bitti_i;
    logic [VERI_BIT-1:0]   birim_sonuc_i;
    logic                  sonuc_gecerli_o;
    logic [VERI_BIT-1:0]   sonuc_o;
    logic [ETIKET_BIT-1:0] sonuc_etiket_o;
    logic                  hata_o;

    // Environment side: execute stage plus the shared unit.
    modport master (
        output istek_gecerli_i, istek_kod_i, istek_islec1_i, istek_islec2_i, istek_etiket_i,
        output bosalt_i, cek_duraklat_i, birim_bitti_i, birim_sonuc_i,
        input  duraklat_o, birim_baslat_o, birim_kod_o, birim_islec1_o, birim_islec2_o,
        input  birim_iptal_o, sonuc_gecerli_o, sonuc_o, sonuc_etiket_o, hata_o
    );

    // Controller side.
    modport slave (
        input  istek_gecerli_i, istek_kod_i, istek_islec1_i, istek_islec2_i, istek_etiket_i,
        input  bosalt_i, cek_duraklat_i, birim_bitti_i, birim_sonuc_i,
        output duraklat_o, birim_baslat_o, birim_kod_o, birim_islec1_o, birim_islec2_o,
        output birim_iptal_o, sonuc_gecerli_o, sonuc_o, sonuc_etiket_o, hata_o
    );

endinterface

// File: rtl/cok_cevrim_denetleyici.sv
// Sequences a shared iterative mul/div unit for one execute-stage request at a time, with
// flush, watchdog timeout and RISC-V divide corner cases resolved without the unit.
module cok_cevrim_denetleyici
    import cok_cevrim_denetleyici_pkg::*;
#(
    parameter int unsigned VERI_BIT    = 32,
    parameter int unsigned ETIKET_BIT  = 4,
    parameter int unsigned ZAMAN_ASIMI = 64
) (
    input logic                   clk_i,
    input logic                   rst_i,
    cok_cevrim_denetleyici_if.slave bag
);

    localparam int unsigned SAYAC_BIT = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(ZAMAN_ASIMI - 1);
    localparam logic [VERI_BIT-1:0]  TUM_BIR   = '1;
    localparam logic [VERI_BIT-1:0]  EN_NEG    = {1'b1, {(VERI_BIT-1){1'b0}}};

    typedef struct packed {
        logic                ozel;
        logic [VERI_BIT-1:0] deger;
    } kose_t;

    // Divide-by-zero and signed-overflow results defined by the RISC-V M extension.
    function automatic kose_t kose_bul(input mop_e kod, input logic [VERI_BIT-1:0] a,
                                       input logic [VERI_BIT-1:0] b);
        kose_t r;
        r = '0;
        if (kod inside {OpDiv, OpDivu, OpRem, OpRemu}) begin
            if (b == '0) begin
                r.ozel  = 1'b1;
                r.deger = (kod inside {OpRem, OpRemu}) ? a : TUM_BIR;
            end else if ((kod inside {OpDiv, OpRem}) && a == EN_NEG && b == TUM_BIR) begin
                r.ozel  = 1'b1;
                r.deger = (kod == OpDiv) ? EN_NEG : '0;
            end
        end
        return r;
    endfunction

    durum_e                durum_q;
    logic [2:0]            kod_q;
    logic [VERI_BIT-1:0]   islec1_q;
    logic [VERI_BIT-1:0]   islec2_q;
    logic [ETIKET_BIT-1:0] etiket_q;
    logic [VERI_BIT-1:0]   sonuc_q;
    logic [SAYAC_BIT-1:0]  sayac_q;
    logic                  baslat_q;
    logic                  iptal_q;
    logic                  hata_q;
    logic                  gecerli_q;

    logic                  kabul;
    kose_t                 kose;
    logic [SAYAC_BIT-1:0]  sayac_art;

    assign kabul     = bag.istek_gecerli_i && !bag.bosalt_i;
    assign kose      = kose_bul(mop_e'(bag.istek_kod_i), bag.istek_islec1_i, bag.istek_islec2_i);
    assign sayac_art = (sayac_q == SAYAC_SON) ? sayac_q : sayac_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q   <= StBosta;
            kod_q     <= '0;
            islec1_q  <= '0;
            islec2_q  <= '0;
            etiket_q  <= '0;
            sonuc_q   <= '0;
            sayac_q   <= '0;
            baslat_q  <= 1'b0;
            iptal_q   <= 1'b0;
            hata_q    <= 1'b0;
            gecerli_q <= 1'b0;
        end else begin
            baslat_q <= 1'b0;
            iptal_q  <= 1'b0;
            hata_q   <= 1'b0;
            unique case (durum_q)
                StBosta: begin
                    if (kabul) begin
                        kod_q    <= bag.istek_kod_i;
                        islec1_q <= bag.istek_islec1_i;
                        islec2_q <= bag.istek_islec2_i;
                        etiket_q <= bag.istek_etiket_i;
                        if (kose.ozel) begin
                            sonuc_q   <= kose.deger;
                            gecerli_q <= 1'b1;
                            durum_q   <= StSonuc;
                        end else begin
                            baslat_q <= 1'b1;
                            sayac_q  <= '0;
                            durum_q  <= StBekle;
                        end
                    end
                end
                StBekle: begin
                    sayac_q <= sayac_art;
                    // Priority: flush, then done, then watchdog.
                    if (bag.bosalt_i) begin
                        iptal_q <= 1'b1;
                        durum_q <= StBosta;
                    end else if (bag.birim_bitti_i) begin
                        sonuc_q   <= bag.birim_sonuc_i;
                        gecerli_q <= 1'b1;
                        durum_q   <= StSonuc;
                    end else if (sayac_art == SAYAC_SON) begin
                        hata_q  <= 1'b1;
                        iptal_q <= 1'b1;
                        durum_q <= StBosta;
                    end
                end
                StSonuc: begin
                    if (bag.bosalt_i || !bag.cek_duraklat_i) begin
                        gecerli_q <= 1'b0;
                        durum_q   <= StBosta;
                    end
                end
                default: begin
                    gecerli_q <= 1'b0;
                    durum_q   <= StBosta;
                end
            endcase
        end
    end

    // Stall is raised in the same cycle the request arrives.
    assign bag.duraklat_o      = (durum_q == StBekle) || ((durum_q == StBosta) && kabul);
    assign bag.birim_baslat_o  = baslat_q;
    assign bag.birim_kod_o     = kod_q;
    assign bag.birim_islec1_o  = islec1_q;
    assign bag.birim_islec2_o  = islec2_q;
    assign bag.birim_iptal_o   = iptal_q;
    assign bag.sonuc_gecerli_o = gecerli_q;
    assign bag.sonuc_o         = sonuc_q;
    assign bag.sonuc_etiket_o  = etiket_q;
    assign bag.hata_o          = hata_q;

endmodule

// File: tb/tb_cok_cevrim_denetleyici.sv
// Directed self-checking bench for the multi-cycle M-extension controller.
module tb_cok_cevrim_denetleyici;
    import cok_cevrim_denetleyici_pkg::*;

    localparam int unsigned VB = 32;
    localparam int unsigned EB = 4;
    localparam int unsigned ZA = 64;

    logic clk;
    logic rst;
    int   toplam = 0;
    int   hatali = 0;

    cok_cevrim_denetleyici_if #(.VERI_BIT(VB), .ETIKET_BIT(EB)) bag ();

    cok_cevrim_denetleyici #(
        .VERI_BIT   (VB),
        .ETIKET_BIT (EB),
        .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bag  (bag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    task automatic saat();
        @(posedge clk);
        #1;
    endtask

    task automatic istek(input mop_e kod, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        bag.istek_gecerli_i = 1'b1;
        bag.istek_kod_i     = kod;
        bag.istek_islec1_i  = a;
        bag.istek_islec2_i  = b;
        bag.istek_etiket_i  = t;
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        bag.istek_gecerli_i = 1'b0;
        bag.istek_kod_i     = '0;
        bag.istek_islec1_i  = '0;
        bag.istek_islec2_i  = '0;
        bag.istek_etiket_i  = '0;
        bag.bosalt_i        = 1'b0;
        bag.cek_duraklat_i  = 1'b0;
        bag.birim_bitti_i   = 1'b0;
        bag.birim_sonuc_i   = '0;
        repeat (2) saat();
        toplam++;
        if (bag.sonuc_gecerli_o !== 1'b0) begin
            hatali++; $display("FAIL reset_gecerli got=%b want=0", bag.sonuc_gecerli_o);
        end
        toplam++;
        if ({bag.birim_baslat_o, bag.birim_iptal_o, bag.hata_o, bag.duraklat_o} !== 4'b0) begin
            hatali++;
            $display("FAIL reset_pulses got=%b want=0000",
                     {bag.birim_baslat_o, bag.birim_iptal_o, bag.hata_o, bag.duraklat_o});
        end
        toplam++;
        if ({bag.sonuc_o, bag.sonuc_etiket_o, bag.birim_islec1_o} !== '0) begin
            hatali++; $display("FAIL reset_data got=%h/%h/%h want=0", bag.sonuc_o,
                               bag.sonuc_etiket_o, bag.birim_islec1_o);
        end
        rst = 1'b0;
        saat();
    endtask

    task automatic test_div_birim();
        int baslat_say;
        bit duraklat_hep;
        istek(OpDiv, 32'd100, 32'd7, 4'hA);
        #1;
        toplam++;
        if (bag.duraklat_o !== 1'b1) begin
            hatali++; $display("FAIL div_duraklat_ayni got=%b want=1", bag.duraklat_o);
        end
        saat();
        bag.istek_gecerli_i = 1'b0;
        toplam++;
        if (bag.birim_baslat_o !== 1'b1) begin
            hatali++; $display("FAIL div_baslat got=%b want=1", bag.birim_baslat_o);
        end
        toplam++;
        if ({bag.birim_kod_o, bag.birim_islec1_o, bag.birim_islec2_o} !== {3'd4, 32'd100, 32'd7})
        begin
            hatali++; $display("FAIL div_latch got=%0d/%0d/%0d want=4/100/7", bag.birim_kod_o,
                               bag.birim_islec1_o, bag.birim_islec2_o);
        end
        baslat_say   = 1;
        duraklat_hep = 1;
        for (int i = 0; i < 33; i++) begin
            saat();
            if (bag.birim_baslat_o) baslat_say++;
            if (!bag.duraklat_o || bag.sonuc_gecerli_o) duraklat_hep = 0;
        end
        bag.birim_bitti_i = 1'b1;
        bag.birim_sonuc_i = 32'd14;
        saat();
        bag.birim_bitti_i = 1'b0;
        toplam++;
        if (baslat_say != 1) begin
            hatali++; $display("FAIL div_baslat_say got=%0d want=1", baslat_say);
        end
        toplam++;
        if (!duraklat_hep) begin
            hatali++; $display("FAIL div_duraklat_bekle got=dropped want=held");
        end
        toplam++;
        if ({bag.sonuc_gecerli_o, bag.sonuc_o, bag.sonuc_etiket_o} !== {1'b1, 32'd14, 4'hA})
        begin
            hatali++; $display("FAIL div_sonuc got=%b/%0d/%h want=1/14/a", bag.sonuc_gecerli_o,
                               bag.sonuc_o, bag.sonuc_etiket_o);
        end
        toplam++;
        if (bag.duraklat_o !== 1'b0) begin
            hatali++; $display("FAIL div_duraklat_sonuc got=%b want=0", bag.duraklat_o);
        end
        saat();
        toplam++;
        if (bag.sonuc_gecerli_o !== 1'b0) begin
            hatali++; $display("FAIL div_bosta got=%b want=0", bag.sonuc_gecerli_o);
        end
    endtask

    task automatic test_sifira_bolme();
        mop_e        kodlar[4] = '{OpDivu, OpRemu, OpDiv, OpRem};
        logic [31:0] a_tab[4]  = '{32'd5, 32'd5, 32'd7, 32'd7};
        logic [31:0] bek[4]    = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd7};
        for (int i = 0; i < 4; i++) begin
            istek(kodlar[i], a_tab[i], 32'd0, 4'(i + 2));
            #1;
            toplam++;
            if (bag.duraklat_o !== 1'b1) begin
                hatali++; $display("FAIL sifir_duraklat[%0d] got=%b want=1", i, bag.duraklat_o);
            end
            saat();
            bag.istek_gecerli_i = 1'b0;
            toplam++;
            if (bag.birim_baslat_o !== 1'b0) begin
                hatali++; $display("FAIL sifir_baslat[%0d] got=%b want=0", i, bag.birim_baslat_o);
            end
            toplam++;
            if ({bag.sonuc_gecerli_o, bag.sonuc_o, bag.sonuc_etiket_o} !== {1'b1, bek[i], 4'(i + 2)})
            begin
                hatali++; $display("FAIL sifir_sonuc[%0d] got=%b/%h/%h want=1/%h/%h", i,
                                   bag.sonuc_gecerli_o, bag.sonuc_o, bag.sonuc_etiket_o, bek[i],
                                   4'(i + 2));
            end
            saat();
            toplam++;
            if (bag.sonuc_gecerli_o !== 1'b0) begin
                hatali++; $display("FAIL sifir_bosta[%0d] got=%b want=0", i, bag.sonuc_gecerli_o);
            end
        end
    endtask

    task automatic test_tasma();
        mop_e        kodlar[2] = '{OpDiv, OpRem};
        logic [31:0] bek[2]    = '{32'h8000_0000, 32'd0};
        for (int i = 0; i < 2; i++) begin
            istek(kodlar[i], 32'h8000_0000, 32'hFFFF_FFFF, 4'h7);
            saat();
            bag.istek_gecerli_i = 1'b0;
            toplam++;
            if ({bag.birim_baslat_o, bag.sonuc_gecerli_o, bag.sonuc_o} !== {2'b01, bek[i]}) begin
                hatali++; $display("FAIL tasma[%0d] got=%b/%b/%h want=0/1/%h", i,
                                   bag.birim_baslat_o, bag.sonuc_gecerli_o, bag.sonuc_o, bek[i]);
            end
            saat();
        end
    endtask

    task automatic test_bosalt();
        bit gecerli_goruldu;
        istek(OpDiv, 32'd50, 32'd5, 4'h3);
        saat();
        bag.istek_gecerli_i = 1'b0;
        saat();
        saat();
        bag.bosalt_i = 1'b1;
        saat();
        bag.bosalt_i = 1'b0;
        toplam++;
        if ({bag.birim_iptal_o, bag.duraklat_o, bag.sonuc_gecerli_o} !== 3'b100) begin
            hatali++; $display("FAIL bosalt_iptal got=%b want=100",
                               {bag.birim_iptal_o, bag.duraklat_o, bag.sonuc_gecerli_o});
        end
        saat();
        toplam++;
        if (bag.birim_iptal_o !== 1'b0) begin
            hatali++; $display("FAIL bosalt_iptal_tek got=%b want=0", bag.birim_iptal_o);
        end
        gecerli_goruldu = 0;
        repeat (8) saat();
        bag.birim_bitti_i = 1'b1;
        bag.birim_sonuc_i = 32'd123;
        saat();
        bag.birim_bitti_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bag.sonuc_gecerli_o || bag.birim_baslat_o || bag.duraklat_o) gecerli_goruldu = 1;
            saat();
        end
        toplam++;
        if (gecerli_goruldu) begin
            hatali++; $display("FAIL bosalt_gec_bitti got=activity want=idle");
        end
        // Flush while a request is offered in idle: nothing is accepted.
        istek(OpDiv, 32'd10, 32'd3, 4'h5);
        bag.bosalt_i = 1'b1;
        #1;
        toplam++;
        if (bag.duraklat_o !== 1'b0) begin
            hatali++; $display("FAIL bosalt_bosta_duraklat got=%b want=0", bag.duraklat_o);
        end
        saat();
        bag.istek_gecerli_i = 1'b0;
        bag.bosalt_i        = 1'b0;
        toplam++;
        if ({bag.birim_baslat_o, bag.sonuc_gecerli_o} !== 2'b00) begin
            hatali++; $display("FAIL bosalt_bosta got=%b want=00",
                               {bag.birim_baslat_o, bag.sonuc_gecerli_o});
        end
        // Flush beats a downstream stall in the result state.
        istek(OpDivu, 32'd5, 32'd0, 4'h2);
        bag.cek_duraklat_i = 1'b1;
        saat();
        bag.istek_gecerli_i = 1'b0;
        bag.bosalt_i        = 1'b1;
        saat();
        bag.bosalt_i       = 1'b0;
        bag.cek_duraklat_i = 1'b0;
        toplam++;
        if (bag.sonuc_gecerli_o !== 1'b0) begin
            hatali++; $display("FAIL bosalt_sonuc got=%b want=0", bag.sonuc_gecerli_o);
        end
    endtask

    task automatic test_zaman_asimi();
        bit sessiz;
        istek(OpMulhu, 32'd3, 32'd4, 4'h6);
        saat();
        bag.istek_gecerli_i = 1'b0;
        sessiz = 1;
        for (int i = 0; i < 63; i++) begin
            if (bag.hata_o || bag.birim_iptal_o || !bag.duraklat_o) sessiz = 0;
            if (i < 62) saat();
        end
        toplam++;
        if (!sessiz) begin
            hatali++; $display("FAIL zaman_erken got=early_event want=quiet_wait");
        end
        saat();
        toplam++;
        if ({bag.hata_o, bag.birim_iptal_o, bag.duraklat_o, bag.sonuc_gecerli_o} !== 4'b1100)
        begin
            hatali++; $display("FAIL zaman_hata got=%b want=1100",
                {bag.hata_o, bag.birim_iptal_o, bag.duraklat_o, bag.sonuc_gecerli_o});
        end
        saat();
        toplam++;
        if ({bag.hata_o, bag.birim_iptal_o} !== 2'b00) begin
            hatali++; $display("FAIL zaman_tek got=%b want=00", {bag.hata_o, bag.birim_iptal_o});
        end
        // Done in the watchdog cycle wins over the timeout.
        istek(OpMul, 32'd7, 32'd11, 4'h4);
        saat();
        bag.istek_gecerli_i = 1'b0;
        repeat (62) saat();
        bag.birim_bitti_i = 1'b1;
        bag.birim_sonuc_i = 32'd77;
        saat();
        bag.birim_bitti_i = 1'b0;
        toplam++;
        if ({bag.sonuc_gecerli_o, bag.hata_o, bag.birim_iptal_o, bag.sonuc_o} !==
            {3'b100, 32'd77}) begin
            hatali++; $display("FAIL zaman_bitti got=%b%b%b/%0d want=100/77", bag.sonuc_gecerli_o,
                               bag.hata_o, bag.birim_iptal_o, bag.sonuc_o);
        end
        saat();
    endtask

    task automatic test_cek_duraklat();
        int gecerli_say;
        bit kararli;
        istek(OpMul, 32'd6, 32'd7, 4'h9);
        saat();
        saat();
        saat();
        bag.birim_bitti_i  = 1'b1;
        bag.birim_sonuc_i  = 32'd42;
        bag.cek_duraklat_i = 1'b1;
        saat();
        bag.birim_bitti_i = 1'b0;
        bag.birim_sonuc_i = 32'd0;
        gecerli_say = 0;
        kararli     = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bag.cek_duraklat_i  = 1'b0;
                bag.istek_gecerli_i = 1'b0;
                #1;
            end
            if (bag.sonuc_gecerli_o) gecerli_say++;
            if (bag.sonuc_o !== 32'd42 || bag.sonuc_etiket_o !== 4'h9 || bag.birim_baslat_o ||
                bag.duraklat_o) kararli = 0;
            saat();
        end
        toplam++;
        if (gecerli_say != 4) begin
            hatali++; $display("FAIL cek_sure got=%0d want=4", gecerli_say);
        end
        toplam++;
        if (!kararli) begin
            hatali++; $display("FAIL cek_kararli got=changed want=42/9_stable");
        end
        toplam++;
        if ({bag.sonuc_gecerli_o, bag.birim_baslat_o, bag.duraklat_o} !== 3'b000) begin
            hatali++; $display("FAIL cek_tekrar_kabul got=%b want=000",
                {bag.sonuc_gecerli_o, bag.birim_baslat_o, bag.duraklat_o});
        end
    endtask

    task automatic test_async_reset();
        istek(OpDiv, 32'd9, 32'd2, 4'h1);
        saat();
        bag.istek_gecerli_i = 1'b0;
        toplam++;
        if (bag.birim_baslat_o !== 1'b1) begin
            hatali++; $display("FAIL arst_on_baslat got=%b want=1", bag.birim_baslat_o);
        end
        #2;
        rst = 1'b1;
        #1;
        toplam++;
        if ({bag.birim_baslat_o, bag.duraklat_o, bag.birim_kod_o, bag.birim_islec1_o,
             bag.sonuc_o} !== '0) begin
            hatali++; $display("FAIL arst_hemen got=%b%b/%0d/%0d/%0d want=0", bag.birim_baslat_o,
                bag.duraklat_o, bag.birim_kod_o, bag.birim_islec1_o, bag.sonuc_o);
        end
        saat();
        rst = 1'b0;
        // Done seen outside the wait state is ignored.
        bag.birim_bitti_i = 1'b1;
        bag.birim_sonuc_i = 32'd5;
        saat();
        bag.birim_bitti_i = 1'b0;
        toplam++;
        if ({bag.sonuc_gecerli_o, bag.duraklat_o} !== 2'b00) begin
            hatali++; $display("FAIL arst_bitti got=%b want=00",
                               {bag.sonuc_gecerli_o, bag.duraklat_o});
        end
    endtask

    initial begin
        test_reset();
        test_div_birim();
        test_sifira_bolme();
        test_tasma();
        test_bosalt();
        test_zaman_asimi();
        test_cek_duraklat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule

// File: doc/cok_cevrim_denetleyici.md
Name: cok_cevrim_denetleyici

Overview:
- Controller that lets the execute stage use a shared iterative multiply/divide unit for RV32M operations.
- Accepts one M-extension request from the execute stage and stalls the pipeline while the operation runs.
- Sequences the external unit with a start/done handshake and returns a tagged result to the execute stage.
- Handles flush and watchdog timeout, and short-circuits the RISC-V divide corner cases without starting the unit.

Parameters:
- VERI_BIT, 32, operand/result width.
- ETIKET_BIT, 4, uop tag width.
- ZAMAN_ASIMI, 64, maximum number of cycles in BEKLE before the watchdog error fires.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, asynchronous, active-high.
- istek_gecerli_i in 1: valid M-extension request from the execute stage.
- istek_kod_i in 3: operation; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- istek_islec1_i in VERI_BIT: rs1 value.
- istek_islec2_i in VERI_BIT: rs2 value.
- istek_etiket_i in ETIKET_BIT: uop tag.
- bosalt_i in 1: pipeline flush.
- cek_duraklat_i in 1: downstream stall.
- duraklat_o out 1: stall request to the pipeline.
- birim_baslat_o out 1: one-cycle start pulse to the unit.
- birim_kod_o out 3: latched operation code.
- birim_islec1_o out VERI_BIT: latched rs1.
- birim_islec2_o out VERI_BIT: latched rs2.
- birim_iptal_o out 1: one-cycle abort pulse to the unit.
- birim_bitti_i in 1: unit done.
- birim_sonuc_i in VERI_BIT: unit result, valid with birim_bitti_i.
- sonuc_gecerli_o out 1: result valid.
- sonuc_o out VERI_BIT: result.
- sonuc_etiket_o out ETIKET_BIT: result tag.
- hata_o out 1: one-cycle watchdog timeout flag.

Behaviour:
- Reset: asynchronous. State goes to BOSTA; counter, latches and all outputs go to 0.
- States: BOSTA, BEKLE, SONUC.
- BOSTA:
  - duraklat_o = istek_gecerli_i && !bosalt_i, combinational, so the stall appears in the same cycle as the request.
  - Accept condition: istek_gecerli_i && !bosalt_i. On accept, latch kod, operands and tag.
  - Divide by zero (kod 4..7, islec2 == 0): go to SONUC without starting the unit. Result is 0xFFFFFFFF for DIV/DIVU; islec1 for REM/REMU.
  - Signed overflow (kod 4 or 6, islec1 == 0x80000000, islec2 == 0xFFFFFFFF): go to SONUC. Result is 0x80000000 for DIV; 0 for REM.
  - All other requests: birim_baslat_o = 1 in the next cycle (first BEKLE cycle), counter cleared, go to BEKLE.
- BEKLE:
  - duraklat_o = 1.
  - Counter increments every cycle.
  - On birim_bitti_i: capture birim_sonuc_i, go to SONUC.
  - When the counter reaches ZAMAN_ASIMI-1 without done: hata_o = 1, birim_iptal_o = 1, go to BOSTA with no result.
- SONUC:
  - duraklat_o = 0.
  - sonuc_gecerli_o = 1, with sonuc_o and sonuc_etiket_o held stable.
  - istek_gecerli_i is ignored in this state, so the re-presented uop is not accepted again.
  - If cek_duraklat_i = 1, stay in SONUC; otherwise go to BOSTA next cycle.
- Flush priority: bosalt_i beats every other event.
  - BEKLE: birim_iptal_o = 1, go to BOSTA.
  - SONUC: drop the result, go to BOSTA.
  - BOSTA: the request is not accepted.
- Simultaneous events:
  - birim_bitti_i together with timeout: done wins, hata_o = 0.
  - birim_bitti_i together with bosalt_i: flush wins, result discarded.
- birim_bitti_i seen outside BEKLE is ignored.
- Counter width is clog2(ZAMAN_ASIMI); the counter saturates and never wraps.
- Latency, accept to sonuc_gecerli_o:
  - Corner case: 1 cycle.
  - Unit path: N+2 cycles, where done arrives N cycles after the start pulse.

Decomposition:
- Shared package/header: M-extension operation codes, state encodings, and corner-case constants (all-ones, 0x80000000).
- No sub-module. The corner-case detector is a small combinational function inside the block.

Test Plan:
- DIV, islec1 = 100, islec2 = 7, done 33 cycles after start, result 14 → baslat pulses once; duraklat high throughout BEKLE; sonuc_gecerli_o = 1 with 14 and the correct tag; back to BOSTA.
- DIVU, islec2 = 0, islec1 = 5 → no baslat; next cycle sonuc = 0xFFFFFFFF. Same stimulus with REMU → sonuc = 5.
- DIV, 0x80000000 / 0xFFFFFFFF → sonuc = 0x80000000. Same stimulus with REM → sonuc = 0.
- bosalt_i in the 3rd BEKLE cycle → iptal pulses once; no sonuc_gecerli_o; a done 10 cycles later is ignored.
- Unit never completes → hata_o pulses in the cycle the counter reaches 63 (ZAMAN_ASIMI-1); iptal pulses; state returns to BOSTA.
- MUL completes while cek_duraklat_i = 1 for 3 cycles → sonuc held 4 cycles; request held during SONUC is not re-accepted. Async rst_i mid-BEKLE → all outputs go to 0 immediately.
